// File: rtl/aes_key_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl_if
// Description : Bundles the key-load handshake, the round-key read port and
//               the link to the external single-round expansion datapath.
//               slave  : seen from the key-schedule controller
//               master : seen from the key loader / round pipeline / datapath
// Signals     : start, key_in          key-load request and cipher key
//               busy, ready, done      expansion status
//               rk_addr, rk_data       round-key read port (combinational)
//               exp_key_in, exp_round  operands to the expansion datapath
//               exp_enable             datapath enable
//               exp_key_out, exp_done  datapath result and valid flag
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_sched_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         ready;
  logic         done;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] exp_key_in;
  logic [3:0]   exp_round;
  logic         exp_enable;
  logic [127:0] exp_key_out;
  logic         exp_done;

  modport slave (
    input  start, key_in, rk_addr, exp_key_out, exp_done,
    output busy, ready, done, rk_data, exp_key_in, exp_round, exp_enable
  );

  modport master (
    output start, key_in, rk_addr, exp_key_out, exp_done,
    input  busy, ready, done, rk_data, exp_key_in, exp_round, exp_enable
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : AES-128 key-expansion sequencer and round-key store. Drives
//               an external single-round datapath ten times, feeding each
//               round key back as the next input, and keeps keys 0..10 in a
//               register file read combinationally by index.
// Ports       : clk    system clock, rising edge
//               reset  asynchronous active-high reset
//               bus    aes_key_sched_ctrl_if.slave (handshake, read port,
//                      expansion datapath link)
// Options     : KEY_SCHED_CACHE_EN - when defined, a start with the already
//               expanded key (ready=1, key_in==rk[0]) skips the expansion and
//               finishes on the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  aes_key_sched_ctrl_if.slave  bus
);

  localparam logic [3:0] c_LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_round;
  logic [127:0] r_cur;
  logic         r_ready;
  logic         w_accept;     // start taken in IDLE
  logic         w_round_wr;   // datapath result captured this edge
  logic         w_cache_hit;
  logic [127:0] w_rk [0:10];

`ifdef KEY_SCHED_CACHE_EN
  // Key already expanded: nothing to recompute.
  assign w_cache_hit = r_ready && (bus.key_in == w_rk[0]);
`else
  assign w_cache_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_round_wr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_cache_hit ? ST_FIN : ST_GAP;
        end
      end
      // One idle cycle lets the datapath drop its done flag before the next
      // enable, so a stale exp_done is never taken as the next result.
      ST_GAP: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.exp_done) begin
          w_round_wr  = 1'b1;
          w_state_nxt = (r_round == c_LAST_ROUND) ? ST_FIN : ST_GAP;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Round counter, feedback key and ready flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round <= 4'd0;
      r_cur   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_accept) begin
        r_round <= 4'd1;
        r_cur   <= bus.key_in;
        // A cache hit keeps ready high; any real expansion invalidates it.
        if (!w_cache_hit) r_ready <= 1'b0;
      end else if (w_round_wr) begin
        r_cur <= bus.exp_key_out;
        // ready rises on entry to FIN so it coincides with the done pulse.
        if (r_round == c_LAST_ROUND) r_ready <= 1'b1;
        else                         r_round <= r_round + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-key register file: entry 0 loads the cipher key on accept, entry n
  // loads the datapath result of round n.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_rk
      logic         r_entry;
      logic [127:0] r_key;
      logic         w_we;

      assign w_we = (gi == 0) ? w_accept
                              : (w_round_wr && (r_round == 4'(gi)));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_key <= '0;
        end else if (w_we) begin
          r_key <= (gi == 0) ? bus.key_in : bus.exp_key_out;
        end
      end

      assign r_entry  = 1'b0;
      assign w_rk[gi] = r_key;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs (all decoded from registers, so reset clears them immediately)
  // --------------------------------------------------------------------------
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_FIN);
  assign bus.ready      = r_ready;
  assign bus.exp_enable = (r_state == ST_RUN);
  assign bus.exp_key_in = r_cur;
  assign bus.exp_round  = r_round;
  assign bus.rk_data    = (bus.rk_addr <= c_LAST_ROUND) ? w_rk[bus.rk_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Self-checking bench for aes_key_sched_ctrl. Acts as the
//               expansion datapath (programmable latency d) and compares the
//               stored round keys against a word-level AES-128 key expansion
//               reference model.
// Options     : KEY_SCHED_CACHE_EN - selects the expected same-key restart
//               behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic reset;

  aes_key_sched_ctrl_if ifc ();

  aes_key_sched_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

`ifdef KEY_SCHED_CACHE_EN
  localparam bit c_CACHE_ON = 1'b1;
`else
  localparam bit c_CACHE_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] ref_rk [0:10];
  bit           model_ready = 1'b0;
  logic [127:0] model_key   = '0;

  // ---------------------------------------------------------------- checker
  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------- GF(2^8) helpers
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] r, res;
    if (a != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    res = inv ^ 8'h63;
    r   = inv;
    for (int k = 0; k < 4; k++) begin
      r   = {r[6:0], r[7]};
      res = res ^ r;
    end
    return res;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // ------------------------------------------- reference: full expansion
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    model_key = key;
  endtask

  // --------------------------------------- datapath model (latency dp_d)
  function automatic logic [127:0] dp_next(input logic [127:0] prev, input logic [3:0] rnd);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t, n0, n1, n2, n3;
    for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
    t  = subword({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  int           dp_d        = 1;
  int           dp_cnt      = 0;
  logic         dp_spurious = 1'b0;  // done flag shown while not enabled
  logic [127:0] dp_out;

  always @(posedge clk) dp_cnt <= ifc.exp_enable ? dp_cnt + 1 : 0;
  always_comb dp_out = dp_next(ifc.exp_key_in, ifc.exp_round);
  assign ifc.exp_key_out = dp_out;
  assign ifc.exp_done    = ifc.exp_enable ? (dp_cnt == dp_d - 1) : dp_spurious;

  // ------------------------------------------------------------- sequences
  task automatic check_rk(input string pfx);
    logic [127:0] e;
    for (int a = 0; a < 16; a++) begin
      ifc.rk_addr = 4'(a);
      #1;
      e = '0;
      if (a <= 10) e = ref_rk[a];
      check_eq($sformatf("%s_rk%0d", pfx, a), ifc.rk_data, e);
    end
    ifc.rk_addr = 4'd0;
  endtask

  // Starts an expansion of key with datapath latency d and watches it to done.
  // If inj_round is non-zero a one-cycle start with inj_key is pulsed during
  // the RUN phase of that round.
  task automatic run_key(input string tag, input logic [127:0] key, input int d,
                         input bit exp_cache, input int inj_round,
                         input logic [127:0] inj_key);
    int n = 0, rounds_seen = 0, low_run = 0;
    int round_err = 0, gap_err = 0, ready_err = 0;
    bit prev_en = 1'b0, injected = 1'b0;
    dp_d = d;
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.key_in = key;
    @(negedge clk);
    ifc.start = 1'b0;
    n = 1;
    check_eq({tag, "_ready_after_accept"}, 128'(ifc.ready), 128'(exp_cache));
    while (!ifc.done && n < 200) begin
      if (ifc.ready !== exp_cache) ready_err++;
      if (ifc.exp_enable) begin
        if (!prev_en) begin
          rounds_seen++;
          if (low_run != 1) gap_err++;
          if (ifc.exp_round != 4'(rounds_seen)) round_err++;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_en = ifc.exp_enable;
      if (ifc.start) begin
        ifc.start = 1'b0;
      end else if (inj_round != 0 && !injected && ifc.exp_enable &&
                   ifc.exp_round == 4'(inj_round)) begin
        ifc.start  = 1'b1;
        ifc.key_in = inj_key;
        injected   = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    ifc.start = 1'b0;
    check_eq({tag, "_latency"}, 128'(n), exp_cache ? 128'd1 : 128'(1 + 10 * (1 + d)));
    check_eq({tag, "_rounds"}, 128'(rounds_seen), exp_cache ? 128'd0 : 128'd10);
    check_eq({tag, "_gap_err"}, 128'(gap_err), 128'd0);
    check_eq({tag, "_round_err"}, 128'(round_err), 128'd0);
    check_eq({tag, "_ready_err"}, 128'(ready_err), 128'd0);
    check_eq({tag, "_ready_at_done"}, 128'(ifc.ready), 128'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 128'(ifc.done), 128'd0);
    check_eq({tag, "_idle"}, 128'(ifc.busy), 128'd0);
    model_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},   128'(ifc.busy),       128'd0);
    check_eq({tag, "_ready"},  128'(ifc.ready),      128'd0);
    check_eq({tag, "_done"},   128'(ifc.done),       128'd0);
    check_eq({tag, "_en"},     128'(ifc.exp_enable), 128'd0);
    check_eq({tag, "_round"},  128'(ifc.exp_round),  128'd0);
    check_eq({tag, "_keyin"},  ifc.exp_key_in,       128'd0);
  endtask

  // ------------------------------------------------------------------ main
  initial begin : main
    logic [127:0] fips, ka, kb, kc, k;
    int           wait_n, d;
    bit           ec;
    fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    reset = 1'b1;
    ifc.start   = 1'b0;
    ifc.key_in  = '0;
    ifc.rk_addr = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 11; i++) ref_rk[i] = '0;
    check_rk("reset");
    reset = 1'b0;

    // FIPS-197 vector, d=1
    run_key("fips", fips, 1, 1'b0, 0, '0);
    model_expand(fips);
    check_rk("fips");
    ifc.rk_addr = 4'd10; #1;
    check_eq("fips_rk10_const", ifc.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ifc.rk_addr = 4'd1; #1;
    check_eq("fips_rk1_const", ifc.rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    ifc.rk_addr = 4'd0;

    // Slow datapath, d=3
    k = {$urandom, $urandom, $urandom, $urandom};
    run_key("d3", k, 3, 1'b0, 0, '0);
    model_expand(k);
    check_rk("d3");

    // start pulsed during RUN of round 4 must be ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    run_key("inj", ka, 2, 1'b0, 4, kb);
    model_expand(ka);
    check_rk("inj");

    // reset during round 6
    dp_d = 1;
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    ifc.start = 1'b0;
    wait_n = 0;
    while (!(ifc.exp_enable && ifc.exp_round == 4'd6) && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("rst6_reached", 128'(wait_n < 100), 128'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst6");
    ifc.rk_addr = 4'd3; #1;
    check_eq("rst6_rk3", ifc.rk_data, 128'd0);
    ifc.rk_addr = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    model_ready = 1'b0;
    kc = {$urandom, $urandom, $urandom, $urandom};
    run_key("post_rst", kc, 1, 1'b0, 0, '0);
    model_expand(kc);
    check_rk("post_rst");

    // same key restarted after ready
    run_key("same", kc, 1, c_CACHE_ON, 0, '0);
    check_rk("same");

    // randomized runs: latency, spurious done while disabled, repeated keys
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) k = model_key;
      else k = {$urandom, $urandom, $urandom, $urandom};
      d  = int'($urandom_range(1, 4));
      dp_spurious = 1'($urandom_range(0, 1));
      ec = c_CACHE_ON && model_ready && (k == model_key);
      run_key($sformatf("rnd%0d", it), k, d, ec, 0, '0);
      dp_spurious = 1'b0;
      model_expand(k);
      check_rk($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer and round-key store for AES-128 key expansion. It accepts a 128-bit cipher key and drives an external single-round expansion datapath ten times, feeding each round key back as the next input. It stores round keys 0..10 in an internal register file that the cipher rounds read by index. It sits between the key-load interface and the encrypt/decrypt round pipeline.

## Interface
- No parameters. AES-128 only: 10 rounds, 11 stored keys.
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request to expand key_in.
- key_in  input  128  cipher key, sampled on the cycle start is accepted.
- busy  output  1  expansion in progress.
- ready  output  1  all 11 round keys valid.
- done  output  1  one-cycle pulse when expansion completes.
- rk_addr  input  4  round-key index 0..10.
- rk_data  output  128  combinational read of round key rk_addr; 0 for rk_addr>10.
- exp_key_in  output  128  previous round key to the expansion datapath.
- exp_round  output  4  round number 1..10 to the datapath's Rcon lookup.
- exp_enable  output  1  enable to the datapath.
- exp_key_out  input  128  expanded key from the datapath.
- exp_done  input  1  datapath result valid; sampled only while exp_enable=1.

## Operation
- FSM states: IDLE, GAP, RUN, FIN.
- IDLE: exp_enable=0. On start=1: rk[0]<=key_in, cur<=key_in, round<=1, ready<=0, go to GAP.
- GAP: exp_enable=0 for exactly one cycle so the datapath's done flag clears. Go to RUN.
- RUN: exp_enable=1, exp_key_in=cur, exp_round=round. Stay until exp_done=1 is sampled. On that edge: rk[round]<=exp_key_out, cur<=exp_key_out. If round==10, go to FIN; otherwise round<=round+1 and go to GAP.
- FIN: one cycle. done=1, ready<=1. Go to IDLE.
- busy=1 in GAP, RUN and FIN.
- start while busy: ignored.
- start while in IDLE with ready=1: restarts expansion. ready drops on the accept edge.
- exp_done asserted outside RUN: ignored.
- round counter is 4 bits, range 1..10. No wrap occurs: FIN is forced at round 10.
- rk_data reads stored values at all times. During expansion, entries not yet rewritten hold stale data. Consumers must gate reads on ready.

## Timing
- Reset values: busy=0, ready=0, done=0, exp_enable=0, exp_round=0, exp_key_in=0, all rk entries=0, state=IDLE.
- Reset mid-operation takes effect immediately and discards partial keys. There is no done pulse.
- Per round: 1 GAP cycle + d RUN cycles, where d counts the RUN cycles up to and including the one with exp_done=1.
- With d=1, ready rises 21 cycles after the start edge:
  - 1 cycle to accept,
  - 10×2 cycles for the rounds,
  - FIN.
  - done pulses in the same cycle ready rises.
- Read latency of rk_data: 0 cycles (combinational from rk_addr).

## Configuration
- KEY_SCHED_CACHE_EN defined:
  - On start with ready=1 and key_in equal to the stored rk[0], the block skips expansion.
  - It goes directly to FIN on the next cycle: done pulses 1 cycle after start and ready stays 1 throughout.
  - The datapath is not enabled.
  - A different key_in runs a full expansion.
- KEY_SCHED_CACHE_EN undefined: every accepted start runs a full expansion. No key comparator is built.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, datapath model with d=1:
  - done and ready rise 21 cycles after start.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
- Datapath model with d=3: ready at cycle 41. exp_enable is low exactly one cycle between each round. exp_round steps 1..10.
- start pulses during RUN of round 4: ignored. Final keys match the first key only.
- reset asserted during round 6: outputs return to reset values asynchronously, before the next clock edge. A subsequent start expands correctly.
- Same key restarted after ready:
  - With KEY_SCHED_CACHE_EN: done 1 cycle later, exp_enable never rises, ready never drops.
  - Without KEY_SCHED_CACHE_EN: ready drops and the full 21-cycle run repeats.
- rk_addr=11..15: rk_data=0.
